// File: rtl/feat_pkg.sv
// Shared widths, defaults and state encoding for the feature-vector loader.
package feat_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_FEAT  = 41;
    localparam int unsigned FIRST_IDX = 2;
    localparam int unsigned IDX_W     = $clog2(NUM_FEAT);
    localparam int unsigned VEC_W     = NUM_FEAT * DATA_W;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/feat_fill_buf.sv
// Indexed-write register array with parallel read-out; slots below FIRST_IDX read as 0.
module feat_fill_buf
    import feat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    output logic [VEC_W-1:0]  rdata
);

    for (genvar i = 0; i < int'(NUM_FEAT); i++) begin : g_ent
        if (i < int'(FIRST_IDX)) begin : g_zero
            assign rdata[i*DATA_W +: DATA_W] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (we && (widx == IDX_W'(i))) begin
                    q <= wdata;
                end
            end

            assign rdata[i*DATA_W +: DATA_W] = q;
        end
    end

endmodule

// File: rtl/feature_vector_loader.sv
// Assembles serial feature samples into a double-buffered parallel vector with valid/ready.
// Optional counters: define FEATURE_VECTOR_LOADER_CNT_EN to add vec_cnt and err_cnt outputs.
module feature_vector_loader
    import feat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [VEC_W-1:0]  xarray,
`ifdef FEATURE_VECTOR_LOADER_CNT_EN
    output logic [15:0]       vec_cnt,
    output logic [7:0]        err_cnt,
`endif
    output logic              err_len
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               m_valid_q, m_valid_d;
    logic               err_q, err_d;
    logic [VEC_W-1:0]   obuf_q, obuf_src;
    logic [VEC_W-1:0]   fbuf_rd;
    logic               obuf_load;
    logic               fb_we;
    logic               beat, xfer, at_last;

    assign beat    = s_valid && (state_q == FILL);
    assign xfer    = m_valid_q && m_ready;
    assign at_last = (idx_q == IDX_W'(NUM_FEAT - 1));

    feat_fill_buf u_fbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (fb_we),
        .widx  (idx_q),
        .wdata (s_data),
        .rdata (fbuf_rd)
    );

    // Next-state, index and output-buffer load decisions
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;
        fb_we     = 1'b0;
        obuf_load = 1'b0;
        obuf_src  = fbuf_rd;

        if (xfer) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (beat) begin
                    if (s_last && !at_last) begin
                        idx_d = IDX_W'(FIRST_IDX);
                        err_d = 1'b1;
                    end else begin
                        fb_we = 1'b1;
                        if (at_last) begin
                            err_d = !s_last;
                            idx_d = IDX_W'(FIRST_IDX);
                            if (!m_valid_q || m_ready) begin
                                // current beat bypasses fbuf straight into the top slot
                                obuf_load = 1'b1;
                                obuf_src  = {s_data, fbuf_rd[(NUM_FEAT-1)*DATA_W-1:0]};
                                m_valid_d = 1'b1;
                            end else begin
                                state_d = STALL;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            STALL: begin
                if (m_ready) begin
                    obuf_load = 1'b1;
                    m_valid_d = 1'b1;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= IDX_W'(FIRST_IDX);
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            obuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            if (obuf_load) begin
                obuf_q <= obuf_src;
            end
        end
    end

    assign s_ready = (state_q == FILL);
    assign m_valid = m_valid_q;
    assign err_len = err_q;
    assign xarray  = obuf_q;

`ifdef FEATURE_VECTOR_LOADER_CNT_EN
    logic [15:0] vec_cnt_q;
    logic [7:0]  err_cnt_q;

    // Transfer count wraps; error count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (xfer) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
            end
            if (err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign vec_cnt = vec_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_feature_vector_loader.sv
// Directed self-checking bench for feature_vector_loader (table of vectors plus hand sequences).
module tb_feature_vector_loader;
    import feat_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [VEC_W-1:0]  xarray;
    logic              err_len;
`ifdef FEATURE_VECTOR_LOADER_CNT_EN
    logic [15:0]       vec_cnt;
    logic [7:0]        err_cnt;
`endif

    feature_vector_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .xarray  (xarray),
`ifdef FEATURE_VECTOR_LOADER_CNT_EN
        .vec_cnt (vec_cnt),
        .err_cnt (err_cnt),
`endif
        .err_len (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int vec_seen = 0;
    int err_seen = 0;
    logic [VEC_W-1:0] cap = '0;

    typedef struct {
        logic [31:0] base;
        int          n;
        int          last_pos;
        int          exp_vec;
        int          exp_err;
    } row_t;

    row_t rows [5];

    // Observe pulses and transfers mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_len) err_seen++;
            if (m_valid && m_ready) begin
                cap = xarray;
                vec_seen++;
            end
        end
    end

    function automatic logic [DATA_W-1:0] ent(input logic [VEC_W-1:0] v, input int i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [VEC_W-1:0] mk_vec(input logic [31:0] base);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 1; k <= 39; k++) begin
            v[(k+1)*DATA_W +: DATA_W] = DATA_W'(base + 32'(k) - 32'd1);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        int first;
        total++;
        if (act !== exp) begin
            bad++;
            first = -1;
            for (int i = NUM_FEAT - 1; i >= 0; i--) begin
                if (ent(act, i) !== ent(exp, i)) first = i;
            end
            $display("FAIL %s: entry %0d got %0h expected %0h", name, first, ent(act, first), ent(exp, first));
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] base, input int n, input int last_pos);
        for (int k = 1; k <= n; k++) begin
            beat(base + 32'(k) - 32'd1, k == last_pos);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0;

        rows[0] = '{base: 32'd1,          n: 39, last_pos: 39, exp_vec: 1, exp_err: 0};
        rows[1] = '{base: 32'd500,        n: 10, last_pos: 10, exp_vec: 0, exp_err: 1};
        rows[2] = '{base: 32'd1000,       n: 39, last_pos: 39, exp_vec: 1, exp_err: 0};
        rows[3] = '{base: 32'd2000,       n: 39, last_pos: 0,  exp_vec: 1, exp_err: 1};
        rows[4] = '{base: 32'hA000_0000,  n: 39, last_pos: 39, exp_vec: 1, exp_err: 0};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_err_len", 32'(err_len), 32'd0);
        check_vec("rst_xarray", xarray, '0);

        // Single vector, consumer ready: valid the cycle after the last beat
        m_ready = 1'b1;
        send_vec(32'd1, 39, 39);
        check("lat_m_valid", 32'(m_valid), 32'd1);
        check("lat_x0", ent(xarray, 0), 32'd0);
        check("lat_x1", ent(xarray, 1), 32'd0);
        check("lat_x2", ent(xarray, 2), 32'd1);
        check("lat_x40", ent(xarray, 40), 32'd39);
        check_vec("lat_vec", xarray, mk_vec(32'd1));
        idle(1);
        check("lat_m_valid_fall", 32'(m_valid), 32'd0);

        // Back-to-back with consumer stalled: hold then STALL
        m_ready = 1'b0;
        send_vec(32'd1, 39, 39);
        check("b2b_first_valid", 32'(m_valid), 32'd1);
        send_vec(32'd101, 39, 39);
        check("b2b_stall_s_ready", 32'(s_ready), 32'd0);
        check("b2b_stall_m_valid", 32'(m_valid), 32'd1);
        check_vec("b2b_held_vec", xarray, mk_vec(32'd1));
        idle(2);
        check("b2b_held_x2", ent(xarray, 2), 32'd1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check_vec("b2b_first_taken", cap, mk_vec(32'd1));
        check("b2b_second_valid", 32'(m_valid), 32'd1);
        check("b2b_second_x2", ent(xarray, 2), 32'd101);
        check("b2b_s_ready_back", 32'(s_ready), 32'd1);
        check_vec("b2b_second_vec", xarray, mk_vec(32'd101));
        m_ready = 1'b1;
        idle(1);
        check("b2b_drain_m_valid", 32'(m_valid), 32'd0);

        // Asynchronous reset mid-stream and mid-hold
        m_ready = 1'b0;
        send_vec(32'd50, 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", 32'(m_valid), 32'd0);
        check_vec("rst_mid_xarray", xarray, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_vec(32'd7, 39, 39);
        check("rst_hold_pre_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hold_m_valid", 32'(m_valid), 32'd0);
        check_vec("rst_hold_xarray", xarray, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        m_ready = 1'b1;
        send_vec(32'd300, 39, 39);
        check_vec("rst_after_vec", xarray, mk_vec(32'd300));
        idle(2);

        // Table of length scenarios with consumer always ready
        for (int r = 0; r < 5; r++) begin
            v0 = vec_seen;
            e0 = err_seen;
            send_vec(rows[r].base, rows[r].n, rows[r].last_pos);
            idle(3);
            check($sformatf("row%0d_vecs", r), 32'(vec_seen - v0), 32'(rows[r].exp_vec));
            check($sformatf("row%0d_errs", r), 32'(err_seen - e0), 32'(rows[r].exp_err));
            if (rows[r].exp_vec != 0) begin
                check_vec($sformatf("row%0d_data", r), cap, mk_vec(rows[r].base));
            end
        end

`ifdef FEATURE_VECTOR_LOADER_CNT_EN
        check("cnt_vec", 32'(vec_cnt), 32'd5);
        check("cnt_err", 32'(err_cnt), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
